// File: rtl/pagerank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pagerank_pkg
//  Purpose  : Shared types and width helpers for the PageRank scatter engine.
//  Revision : 1.0 - initial release
// ============================================================================
package pagerank_pkg;

    // Scatter engine control states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_NODE_RD   = 3'd1,
        ST_NODE_WAIT = 3'd2,
        ST_DIV       = 3'd3,
        ST_EDGE_RD   = 3'd4,
        ST_EDGE_WAIT = 3'd5,
        ST_EMIT      = 3'd6,
        ST_DONE      = 3'd7
    } scatter_state_t;

    // DEG_W: bits needed to hold any legal out-degree (0..max_deg)
    function automatic int deg_w_of(input int max_deg);
        return $clog2(max_deg + 1);
    endfunction

    // ACC_W: dangling accumulator width; one spare bit beyond nodes * max rank
    function automatic int acc_w_of(input int data_w, input int nodes);
        return data_w + $clog2(nodes) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pagerank_scatter_stream_divider.sv
`default_nettype none
// ============================================================================
//  Module   : rank_divider
//  Purpose  : Restoring unsigned divider, one quotient bit per cycle.
//             The first bit is resolved on the start cycle itself so that
//             done pulses exactly DATA_W cycles after start.
//  Revision : 1.0 - initial release
// ============================================================================
module rank_divider #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [ID_W-1:0]   divisor,
    output logic [DATA_W-1:0] quotient,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [ID_W-1:0]   rem_q, rem_d, dvs_q, dvs_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d, done_q, done_d;
    logic [ID_W-1:0]   src_rem, src_dvs;
    logic [DATA_W-1:0] src_quo;
    logic [ID_W:0]     trial;

    // One restoring step; on start the operands come straight from the ports
    always_comb begin
        src_rem  = start ? '0       : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvs  = start ? divisor  : dvs_q;
        trial    = {src_rem, src_quo[DATA_W-1]};
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (start || active_q) begin
            if (trial >= {1'b0, src_dvs}) begin
                rem_d = ID_W'(trial - {1'b0, src_dvs});
                quo_d = {src_quo[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = trial[ID_W-1:0];
                quo_d = {src_quo[DATA_W-2:0], 1'b0};
            end
        end
        if (start) begin
            dvs_d    = divisor;
            cnt_d    = CNT_W'(DATA_W - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: rtl/pagerank_scatter_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pagerank_scatter_stream
//  Purpose  : CSR scatter engine: per source node computes rank/out_degree
//             once, then streams one (dest, contribution) message per edge.
//             Tracks dangling rank, malformed edges/degrees and completion.
//  Revision : 1.0 - initial release
// ============================================================================
module pagerank_scatter_stream
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_PARTITION = 4,
    parameter int EDGES_IN_PARTITION = 80,
    parameter int TOTAL_NODES        = 1024,
    parameter int MAX_OUT_DEGREE     = 20,
    parameter int DATA_W             = 64,
    parameter int ID_W               = 32
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          start,
    output logic                                          node_rd_en,
    output logic [$clog2(NODES_IN_PARTITION)-1:0]         node_rd_addr,
    input  logic [DATA_W-1:0]                             node_rank,
    input  logic [ID_W-1:0]                               node_degree,
    input  logic [$clog2(EDGES_IN_PARTITION)-1:0]         node_edge_base,
    output logic                                          edge_rd_en,
    output logic [$clog2(EDGES_IN_PARTITION)-1:0]         edge_rd_addr,
    input  logic [ID_W-1:0]                               edge_dest,
    output logic                                          msg_valid,
    input  logic                                          msg_ready,
    output logic [ID_W-1:0]                               msg_dest_id,
    output logic [DATA_W-1:0]                             msg_value,
    output logic                                          busy,
    output logic                                          done,
    output logic [ID_W-1:0]                               msg_count,
    output logic [DATA_W+$clog2(NODES_IN_PARTITION):0]    dangling_sum,
    output logic [1:0]                                    err
);
    localparam int NA_W  = $clog2(NODES_IN_PARTITION);
    localparam int EA_W  = $clog2(EDGES_IN_PARTITION);
    localparam int NI_W  = $clog2(NODES_IN_PARTITION + 1);
    localparam int DEG_W = deg_w_of(MAX_OUT_DEGREE);
    localparam int ACC_W = acc_w_of(DATA_W, NODES_IN_PARTITION);

    localparam logic [NI_W-1:0] NODE_END = NI_W'(NODES_IN_PARTITION);
    localparam logic [ID_W:0]   DEST_LIM = (ID_W + 1)'(TOTAL_NODES);
    localparam logic [ID_W-1:0] DEG_MAX  = ID_W'(MAX_OUT_DEGREE);

    scatter_state_t    state_q, state_d;
    logic [NI_W-1:0]   node_idx_q, node_idx_d;
    logic [DEG_W-1:0]  edge_cnt_q, edge_cnt_d, degree_q, degree_d;
    logic [EA_W-1:0]   edge_base_q, edge_base_d;
    logic [DATA_W-1:0] contrib_q, contrib_d, value_q, value_d;
    logic [ID_W-1:0]   dest_q, dest_d, count_q, count_d;
    logic [ACC_W-1:0]  dang_q, dang_d;
    logic [1:0]        err_q, err_d;
    logic              div_start, div_done, advance, last_edge;
    logic [DATA_W-1:0] div_quotient;

    rank_divider #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (node_rank),
        .divisor  (node_degree),
        .quotient (div_quotient),
        .done     (div_done)
    );

    assign last_edge    = (({1'b0, edge_cnt_q} + (DEG_W + 1)'(1)) == {1'b0, degree_q});
    assign node_rd_addr = node_idx_q[NA_W-1:0];
    assign edge_rd_addr = edge_base_q + EA_W'(edge_cnt_q);

    // Next-state, counters and strobes; the advance step is shared by
    // EDGE_WAIT (dropped edge) and EMIT (accepted message)
    always_comb begin
        state_d     = state_q;
        node_idx_d  = node_idx_q;
        edge_cnt_d  = edge_cnt_q;
        degree_d    = degree_q;
        edge_base_d = edge_base_q;
        contrib_d   = contrib_q;
        value_d     = value_q;
        dest_d      = dest_q;
        count_d     = count_q;
        dang_d      = dang_q;
        err_d       = err_q;
        div_start   = 1'b0;
        advance     = 1'b0;
        node_rd_en  = 1'b0;
        edge_rd_en  = 1'b0;
        msg_valid   = 1'b0;
        done        = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    node_idx_d = '0;
                    count_d    = '0;
                    dang_d     = '0;
                    err_d      = '0;
                    state_d    = ST_NODE_RD;
                end
            end
            ST_NODE_RD: begin
                if (node_idx_q == NODE_END) begin
                    state_d = ST_DONE;
                end else begin
                    node_rd_en = 1'b1;
                    state_d    = ST_NODE_WAIT;
                end
            end
            ST_NODE_WAIT: begin
                if (node_degree == '0) begin
                    dang_d     = dang_q + ACC_W'(node_rank);
                    node_idx_d = node_idx_q + NI_W'(1);
                    state_d    = ST_NODE_RD;
                end else if (node_degree > DEG_MAX) begin
                    err_d[1]   = 1'b1;
                    node_idx_d = node_idx_q + NI_W'(1);
                    state_d    = ST_NODE_RD;
                end else begin
                    degree_d    = DEG_W'(node_degree);
                    edge_base_d = node_edge_base;
                    div_start   = 1'b1;
                    state_d     = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    contrib_d  = div_quotient;
                    edge_cnt_d = '0;
                    state_d    = ST_EDGE_RD;
                end
            end
            ST_EDGE_RD: begin
                edge_rd_en = 1'b1;
                state_d    = ST_EDGE_WAIT;
            end
            ST_EDGE_WAIT: begin
                if ({1'b0, edge_dest} >= DEST_LIM) begin
                    err_d[0] = 1'b1;
                    advance  = 1'b1;
                end else begin
                    dest_d  = edge_dest;
                    value_d = contrib_q;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                msg_valid = 1'b1;
                if (msg_ready) begin
                    count_d = count_q + ID_W'(1);
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (last_edge) begin
                node_idx_d = node_idx_q + NI_W'(1);
                state_d    = ST_NODE_RD;
            end else begin
                edge_cnt_d = edge_cnt_q + DEG_W'(1);
                state_d    = ST_EDGE_RD;
            end
        end
    end

    // State, counters and the registered message/status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            node_idx_q  <= '0;
            edge_cnt_q  <= '0;
            degree_q    <= '0;
            edge_base_q <= '0;
            contrib_q   <= '0;
            value_q     <= '0;
            dest_q      <= '0;
            count_q     <= '0;
            dang_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            node_idx_q  <= node_idx_d;
            edge_cnt_q  <= edge_cnt_d;
            degree_q    <= degree_d;
            edge_base_q <= edge_base_d;
            contrib_q   <= contrib_d;
            value_q     <= value_d;
            dest_q      <= dest_d;
            count_q     <= count_d;
            dang_q      <= dang_d;
            err_q       <= err_d;
        end
    end

    assign msg_dest_id  = dest_q;
    assign msg_value    = value_q;
    assign msg_count    = count_q;
    assign dangling_sum = dang_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pagerank_scatter_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pagerank_scatter_stream
//  Purpose  : Self-checking bench for the PageRank scatter engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pagerank_scatter_stream;
    localparam int DW = 64;

    logic        clock = 1'b0;
    logic        reset, start, msg_ready;
    logic        node_rd_en, edge_rd_en, msg_valid, busy, done;
    logic [1:0]  node_rd_addr;
    logic [63:0] node_rank, msg_value;
    logic [31:0] node_degree, edge_dest, msg_dest_id, msg_count;
    logic [6:0]  node_edge_base, edge_rd_addr;
    logic [66:0] dangling_sum;
    logic [1:0]  err;

    always #5 clock = ~clock;

    pagerank_scatter_stream dut (
        .clock(clock), .reset(reset), .start(start),
        .node_rd_en(node_rd_en), .node_rd_addr(node_rd_addr),
        .node_rank(node_rank), .node_degree(node_degree), .node_edge_base(node_edge_base),
        .edge_rd_en(edge_rd_en), .edge_rd_addr(edge_rd_addr), .edge_dest(edge_dest),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_dest_id(msg_dest_id),
        .msg_value(msg_value), .busy(busy), .done(done), .msg_count(msg_count),
        .dangling_sum(dangling_sum), .err(err)
    );

    // Node and edge memories, one-cycle read latency
    logic [63:0] rank_mem [4];
    logic [31:0] deg_mem  [4];
    logic [6:0]  base_mem [4];
    logic [31:0] edge_mem [128];

    always @(posedge clock) begin
        if (node_rd_en) begin
            node_rank      <= rank_mem[node_rd_addr];
            node_degree    <= deg_mem[node_rd_addr];
            node_edge_base <= base_mem[node_rd_addr];
        end
        if (edge_rd_en) edge_dest <= edge_mem[edge_rd_addr];
    end

    // Ready driver: 0 = always high, 1 = random, 2 = follow manual_ready
    int   ready_mode = 0;
    logic manual_ready = 1'b0;
    initial begin
        msg_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (ready_mode == 0)      msg_ready = 1'b1;
            else if (ready_mode == 1) msg_ready = 1'($urandom_range(0, 1));
            else                      msg_ready = manual_ready;
        end
    end

    // Monitor: collects accepted messages, done pulses and stall-hold violations
    logic [31:0] got_dest [$];
    logic [63:0] got_val  [$];
    int          done_seen = 0;
    int          hold_err  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dest = '0;
    logic [63:0] prev_val  = '0;
    always @(negedge clock) begin
        if (done) done_seen <= done_seen + 1;
        if (prev_stall && !reset &&
            (!msg_valid || msg_dest_id !== prev_dest || msg_value !== prev_val))
            hold_err <= hold_err + 1;
        prev_stall <= msg_valid && !msg_ready;
        prev_dest  <= msg_dest_id;
        prev_val   <= msg_value;
        if (msg_valid && msg_ready) begin
            got_dest.push_back(msg_dest_id);
            got_val.push_back(msg_value);
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: walk the CSR memories with plain arithmetic
    logic [31:0] exp_dest [$];
    logic [63:0] exp_val  [$];
    int          m_cnt;
    logic [66:0] m_dang;
    logic [1:0]  m_err;

    function automatic void model();
        logic [31:0] d;
        exp_dest.delete();
        exp_val.delete();
        m_cnt = 0; m_dang = '0; m_err = '0;
        for (int n = 0; n < 4; n++) begin
            if (deg_mem[n] == 0) begin
                m_dang = m_dang + 67'(rank_mem[n]);
            end else if (deg_mem[n] > 20) begin
                m_err[1] = 1'b1;
            end else begin
                for (int i = 0; i < int'(deg_mem[n]); i++) begin
                    d = edge_mem[(int'(base_mem[n]) + i) % 128];
                    if (d >= 1024) m_err[0] = 1'b1;
                    else begin
                        exp_dest.push_back(d);
                        exp_val.push_back(rank_mem[n] / 64'(deg_mem[n]));
                        m_cnt++;
                    end
                end
            end
        end
    endfunction

    typedef struct packed {
        logic [3:0][63:0]  rank;
        logic [3:0][31:0]  deg;
        logic [3:0][6:0]   base;
        logic [23:0][31:0] edges;
        logic [31:0]       exp_cnt;
        logic [66:0]       exp_dang;
        logic [1:0]        exp_err;
        int                exp_first;
        int                exp_done;
    } vec_t;

    vec_t vecs [4];

    task automatic load_vec(input vec_t v);
        for (int n = 0; n < 4; n++) begin
            rank_mem[n] = v.rank[n];
            deg_mem[n]  = v.deg[n];
            base_mem[n] = v.base[n];
        end
        for (int e = 0; e < 128; e++) edge_mem[e] = (e < 24) ? v.edges[e] : 32'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Run one iteration; cycle 1 is the first cycle after the start edge
    int msg_base;
    task automatic run_iter(input int extra_start, output int first, output int done_cyc);
        int cyc;
        int dbase;
        msg_base = got_dest.size();
        dbase    = done_seen;
        pulse_start();
        cyc = 1; first = -1; done_cyc = -1;
        while (cyc < 4000) begin
            if (msg_valid && first < 0) first = cyc;
            if (done) begin
                done_cyc = cyc;
                chk("done_with_busy", busy, 1);
                break;
            end
            start = (cyc == extra_start);
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            n_total++;
            $display("FAIL done_timeout: got no done, expected done within 4000 cycles");
        end else begin
            @(posedge clock); #1;
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
            chk("done_pulse_count", done_seen - dbase, 1);
        end
    endtask

    task automatic compare_results(input string tag);
        int ng;
        ng = got_dest.size() - msg_base;
        chk({tag, "_n_msgs"}, ng, exp_dest.size());
        for (int i = 0; i < ng && i < exp_dest.size(); i++) begin
            chk({tag, "_dest"}, got_dest[msg_base + i], exp_dest[i]);
            chk({tag, "_value"}, got_val[msg_base + i], exp_val[i]);
        end
        chk({tag, "_msg_count"}, msg_count, m_cnt);
        chk({tag, "_dangling"}, dangling_sum, m_dang);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_hold"}, hold_err, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, msg_valid, 0);
        chk({tag, "_rd_en"}, {node_rd_en, edge_rd_en}, 0);
        chk({tag, "_count"}, msg_count, 0);
        chk({tag, "_dang"}, dangling_sum, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_msg"}, {msg_dest_id, msg_value}, 0);
    endtask

    initial begin
        int first, dcyc, dbase, cyc;
        logic        stable;
        logic [31:0] d0;
        logic [63:0] v0;

        // Vector table: hand-derived expectations
        for (int i = 0; i < 4; i++) vecs[i] = '0;
        // basic fan-out, dangling node, bad degree, truncation
        vecs[0].rank[0] = 64'h100; vecs[0].deg[0] = 2;  vecs[0].base[0] = 0;
        vecs[0].rank[1] = 64'h40;  vecs[0].deg[1] = 0;
        vecs[0].rank[2] = 64'h999; vecs[0].deg[2] = 25; vecs[0].base[2] = 2;
        vecs[0].rank[3] = 64'h64;  vecs[0].deg[3] = 3;  vecs[0].base[3] = 2;
        vecs[0].edges[0] = 1; vecs[0].edges[1] = 3;
        vecs[0].edges[2] = 5; vecs[0].edges[3] = 9; vecs[0].edges[4] = 11;
        vecs[0].exp_cnt = 5; vecs[0].exp_dang = 67'h40; vecs[0].exp_err = 2'b10;
        vecs[0].exp_first = DW + 5; vecs[0].exp_done = 153;
        // out-of-range edge
        vecs[1].rank[0] = 64'h300; vecs[1].deg[0] = 3; vecs[1].base[0] = 0;
        vecs[1].rank[2] = 64'h10;
        vecs[1].rank[3] = 64'h7;   vecs[1].deg[3] = 1; vecs[1].base[3] = 3;
        vecs[1].edges[0] = 5; vecs[1].edges[1] = 1024; vecs[1].edges[2] = 7;
        vecs[1].edges[3] = 1023;
        vecs[1].exp_cnt = 3; vecs[1].exp_dang = 67'h10; vecs[1].exp_err = 2'b01;
        vecs[1].exp_first = DW + 5; vecs[1].exp_done = 149;
        // empty partition: all dangling
        for (int n = 0; n < 4; n++) vecs[2].rank[n] = 64'(n + 1);
        vecs[2].exp_cnt = 0; vecs[2].exp_dang = 67'd10; vecs[2].exp_err = 2'b00;
        vecs[2].exp_first = -1; vecs[2].exp_done = 10;
        // maximum legal degree, full-scale ranks, degree one over the limit
        for (int n = 0; n < 4; n++) vecs[3].rank[n] = '1;
        vecs[3].deg[0] = 20; vecs[3].deg[3] = 21;
        for (int e = 0; e < 20; e++) vecs[3].edges[e] = 32'(e * 50);
        vecs[3].exp_cnt = 20; vecs[3].exp_dang = 67'h1_FFFF_FFFF_FFFF_FFFE;
        vecs[3].exp_err = 2'b10; vecs[3].exp_first = DW + 5; vecs[3].exp_done = 134;

        reset = 1'b1; start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Table-driven runs, ready always high
        ready_mode = 0;
        for (int i = 0; i < 4; i++) begin
            load_vec(vecs[i]);
            model();
            run_iter(-1, first, dcyc);
            compare_results($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_count", i), msg_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_tbl_dang", i), dangling_sum, vecs[i].exp_dang);
            chk($sformatf("vec%0d_tbl_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_first_valid", i), first, vecs[i].exp_first);
            chk($sformatf("vec%0d_done_cycle", i), dcyc, vecs[i].exp_done);
            repeat (2) @(posedge clock);
            #1;
        end
        chk("truncation_value", got_val[2], 64'h21);

        // Backpressure: ready low for 6 cycles while the first message waits
        load_vec(vecs[0]);
        model();
        ready_mode = 2; manual_ready = 1'b0;
        msg_base = got_dest.size();
        pulse_start();
        cyc = 0;
        while (!msg_valid && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("bp_valid_seen", msg_valid, 1);
        d0 = msg_dest_id; v0 = msg_value; stable = 1'b1;
        repeat (6) begin
            @(posedge clock); #1;
            stable = stable & msg_valid & (msg_dest_id == d0) & (msg_value == v0);
        end
        chk("bp_stable", stable, 1);
        chk("bp_held_msg", {d0, v0}, {32'd1, 64'h80});
        manual_ready = 1'b1;
        @(posedge clock); #1;
        manual_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("bp_one_handshake", got_dest.size() - msg_base, 1);
        ready_mode = 0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("bp_done", done, 1);
        @(posedge clock); #1;
        compare_results("bp");

        // Reset during DIV of node 3, after earlier nodes updated the status
        load_vec(vecs[0]);
        model();
        pulse_start();
        repeat (99) @(posedge clock);
        #1;
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_dang", dangling_sum, 67'h40);
        chk("pre_reset_err", err, 2'b10);
        chk("pre_reset_count", msg_count, 2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_zero("mid_reset");
        dbase = done_seen;
        repeat (80) @(posedge clock);
        #1;
        chk("no_done_after_reset", done_seen - dbase, 0);
        chk("idle_after_reset", busy, 0);

        // Rerun with a stray start while busy; it must not disturb the iteration
        run_iter(30, first, dcyc);
        compare_results("rerun");
        chk("rerun_done_cycle", dcyc, 153);
        chk("rerun_first_valid", first, DW + 5);

        // Randomized iterations with random backpressure
        ready_mode = 1;
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 4; n++) begin
                rank_mem[n] = {32'($urandom), 32'($urandom)};
                deg_mem[n]  = 32'($urandom_range(0, 23));
                base_mem[n] = 7'($urandom_range(0, 127));
            end
            for (int e = 0; e < 128; e++)
                edge_mem[e] = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1024, 3000))
                                                          : 32'($urandom_range(0, 1023));
            model();
            run_iter(-1, first, dcyc);
            compare_results($sformatf("rand%0d", r));
            repeat (2) @(posedge clock);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
